// File: rtl/lsu_dmem.sv
// Load/store unit between the core datapath and a synchronous data memory.
// One request per handshake; generates the word address, byte enables and
// lane-replicated write data, waits MEM_LATENCY cycles for load data, and
// returns sign/zero-extended results with a one-cycle response pulse.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | ready for a request; o_req_ready=1
// ACCESS | memory strobe is on the bus this cycle
// WAIT   | load in flight; latency down-counter running
// RESP   | o_rsp_valid is high this cycle, back to IDLE next
module lsu_dmem #(
    parameter int data_size    = 1024,
    parameter int address_size = 32,
    parameter int MEM_LATENCY  = 1
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_req_valid,
    output logic                           o_req_ready,
    input  logic                           i_req_we,
    input  logic [2:0]                     i_req_funct3,
    input  logic [address_size-1:0]        i_req_addr,
    input  logic [address_size-1:0]        i_req_wdata,
    output logic                           o_rsp_valid,
    output logic [address_size-1:0]        o_rsp_rdata,
    output logic                           o_rsp_err,
    output logic                           o_mem_en,
    output logic                           o_mem_we,
    output logic [$clog2(data_size)-1:0]   o_mem_addr,
    output logic [3:0]                     o_mem_be,
    output logic [31:0]                    o_mem_wdata,
    input  logic [31:0]                    i_mem_rdata
);
    localparam int AW    = $clog2(data_size);
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t                  r_state, w_state_nxt;
    logic [2:0]              r_funct3, w_funct3_nxt;
    logic [1:0]              r_lo, w_lo_nxt;
    logic                    r_we, w_we_nxt;
    logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
    logic                    r_rsp_valid, w_rsp_valid_nxt;
    logic [address_size-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
    logic                    r_rsp_err, w_rsp_err_nxt;
    logic                    r_mem_en, w_mem_en_nxt;
    logic                    r_mem_we, w_mem_we_nxt;
    logic [AW-1:0]           r_mem_addr, w_mem_addr_nxt;
    logic [3:0]              r_mem_be, w_mem_be_nxt;
    logic [31:0]             r_mem_wdata, w_mem_wdata_nxt;

    logic                    w_misaligned, w_illegal, w_err;
    logic [3:0]              w_be;
    logic [31:0]             w_wdata;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [31:0]             w_ext;
    logic                    w_unused_addr;

    // Bits above the DMEM range are dropped so addresses wrap modulo its size.
    assign w_unused_addr = ^i_req_addr[address_size-1:AW+2];

    // Request decode: alignment/legality check plus store lane steering.
    always_comb begin
        w_misaligned = 1'b0;
        case (i_req_funct3[1:0])
            2'b01:   w_misaligned = i_req_addr[0];
            2'b10:   w_misaligned = (i_req_addr[1:0] != 2'b00);
            default: w_misaligned = 1'b0;
        endcase
        if (i_req_we)
            w_illegal = (i_req_funct3 >= 3'b011);
        else
            w_illegal = (i_req_funct3 == 3'b011) || (i_req_funct3[2:1] == 2'b11);
        w_err   = w_misaligned | w_illegal;
        w_be    = 4'b1111;
        w_wdata = i_req_wdata[31:0];
        if (i_req_we) begin
            case (i_req_funct3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << i_req_addr[1:0];
                    w_wdata = {4{i_req_wdata[7:0]}};
                end
                2'b01: begin
                    w_be    = i_req_addr[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{i_req_wdata[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = i_req_wdata[31:0];
                end
            endcase
        end
    end

    // Load lane select and sign/zero extension of the returned word.
    always_comb begin
        case (r_lo)
            2'd0:    w_byte = i_mem_rdata[7:0];
            2'd1:    w_byte = i_mem_rdata[15:8];
            2'd2:    w_byte = i_mem_rdata[23:16];
            default: w_byte = i_mem_rdata[31:24];
        endcase
        w_half = r_lo[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b010:  w_ext = i_mem_rdata;
            3'b100:  w_ext = {24'd0, w_byte};
            3'b101:  w_ext = {16'd0, w_half};
            default: w_ext = 32'd0;
        endcase
    end

    // Next-state and registered-output logic; strobes default low every cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_funct3_nxt    = r_funct3;
        w_lo_nxt        = r_lo;
        w_we_nxt        = r_we;
        w_cnt_nxt       = r_cnt;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_rdata_nxt = '0;
        w_rsp_err_nxt   = 1'b0;
        w_mem_en_nxt    = 1'b0;
        w_mem_we_nxt    = 1'b0;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_be_nxt    = r_mem_be;
        w_mem_wdata_nxt = r_mem_wdata;
        case (r_state)
            IDLE: begin
                if (i_req_valid) begin
                    w_funct3_nxt = i_req_funct3;
                    w_lo_nxt     = i_req_addr[1:0];
                    w_we_nxt     = i_req_we;
                    if (w_err) begin
                        w_state_nxt     = RESP;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt     = ACCESS;
                        w_mem_en_nxt    = 1'b1;
                        w_mem_we_nxt    = i_req_we;
                        w_mem_addr_nxt  = i_req_addr[2 +: AW];
                        w_mem_be_nxt    = w_be;
                        w_mem_wdata_nxt = w_wdata;
                    end
                end
            end
            ACCESS: begin
                if (r_we) begin
                    w_state_nxt     = RESP;
                    w_rsp_valid_nxt = 1'b1;
                end else begin
                    w_state_nxt = WAIT;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt     = RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = address_size'(w_ext);
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_funct3    <= '0;
            r_lo        <= '0;
            r_we        <= 1'b0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_funct3    <= w_funct3_nxt;
            r_lo        <= w_lo_nxt;
            r_we        <= w_we_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_mem_en    <= w_mem_en_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_be    <= w_mem_be_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
        end
    end

    assign o_req_ready = (r_state == IDLE);
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;
    assign o_mem_en    = r_mem_en;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_be    = r_mem_be;
    assign o_mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_lsu_dmem.sv
// Directed bench for lsu_dmem: one instance with MEM_LATENCY=1, one with 3,
// each attached to a behavioural synchronous RAM. Expected responses are queued
// when a request is driven and popped when the unit answers.
module tb_lsu_dmem;
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        sel;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        v1, v3;

    logic        r1_ready, r1_rsp_valid, r1_rsp_err, r1_mem_en, r1_mem_we;
    logic [31:0] r1_rsp_rdata, r1_mem_wdata, r1_mem_rdata;
    logic [9:0]  r1_mem_addr;
    logic [3:0]  r1_mem_be;
    logic        r3_ready, r3_rsp_valid, r3_rsp_err, r3_mem_en, r3_mem_we;
    logic [31:0] r3_rsp_rdata, r3_mem_wdata, r3_mem_rdata;
    logic [9:0]  r3_mem_addr;
    logic [3:0]  r3_mem_be;

    logic        s_ready, s_rsp_valid, s_rsp_err, s_mem_en, s_mem_we;
    logic [31:0] s_rsp_rdata, s_mem_wdata;
    logic [9:0]  s_mem_addr;
    logic [3:0]  s_mem_be;

    int   checks = 0;
    int   errors = 0;
    rsp_t sb_q[$];

    assign v1 = req_valid & ~sel;
    assign v3 = req_valid & sel;

    lsu_dmem #(.data_size(1024), .address_size(32), .MEM_LATENCY(1)) dut1 (
        .i_clk(clk), .i_reset(reset), .i_req_valid(v1), .o_req_ready(r1_ready),
        .i_req_we(req_we), .i_req_funct3(req_funct3), .i_req_addr(req_addr),
        .i_req_wdata(req_wdata), .o_rsp_valid(r1_rsp_valid), .o_rsp_rdata(r1_rsp_rdata),
        .o_rsp_err(r1_rsp_err), .o_mem_en(r1_mem_en), .o_mem_we(r1_mem_we),
        .o_mem_addr(r1_mem_addr), .o_mem_be(r1_mem_be), .o_mem_wdata(r1_mem_wdata),
        .i_mem_rdata(r1_mem_rdata));

    lsu_dmem #(.data_size(1024), .address_size(32), .MEM_LATENCY(3)) dut3 (
        .i_clk(clk), .i_reset(reset), .i_req_valid(v3), .o_req_ready(r3_ready),
        .i_req_we(req_we), .i_req_funct3(req_funct3), .i_req_addr(req_addr),
        .i_req_wdata(req_wdata), .o_rsp_valid(r3_rsp_valid), .o_rsp_rdata(r3_rsp_rdata),
        .o_rsp_err(r3_rsp_err), .o_mem_en(r3_mem_en), .o_mem_we(r3_mem_we),
        .o_mem_addr(r3_mem_addr), .o_mem_be(r3_mem_be), .o_mem_wdata(r3_mem_wdata),
        .i_mem_rdata(r3_mem_rdata));

    always_comb begin
        s_ready     = sel ? r3_ready     : r1_ready;
        s_rsp_valid = sel ? r3_rsp_valid : r1_rsp_valid;
        s_rsp_err   = sel ? r3_rsp_err   : r1_rsp_err;
        s_rsp_rdata = sel ? r3_rsp_rdata : r1_rsp_rdata;
        s_mem_en    = sel ? r3_mem_en    : r1_mem_en;
        s_mem_we    = sel ? r3_mem_we    : r1_mem_we;
        s_mem_addr  = sel ? r3_mem_addr  : r1_mem_addr;
        s_mem_be    = sel ? r3_mem_be    : r1_mem_be;
        s_mem_wdata = sel ? r3_mem_wdata : r1_mem_wdata;
    end

    // Synchronous RAM, 1-cycle read; data is poisoned when not valid.
    logic [31:0] mem1 [0:1023];
    logic [31:0] pipe1;
    logic        pv1 = 1'b0;
    always @(posedge clk) begin
        pv1 <= r1_mem_en && !r1_mem_we;
        if (r1_mem_en) begin
            pipe1 <= mem1[r1_mem_addr];
            if (r1_mem_we)
                for (int b = 0; b < 4; b++)
                    if (r1_mem_be[b]) mem1[r1_mem_addr][8*b +: 8] <= r1_mem_wdata[8*b +: 8];
        end
    end
    assign r1_mem_rdata = pv1 ? pipe1 : 32'hBAD0BAD0;

    // Synchronous RAM, 3-cycle read pipeline.
    logic [31:0] mem3 [0:1023];
    logic [31:0] pipe3 [0:2];
    logic [2:0]  pv3 = 3'b000;
    always @(posedge clk) begin
        pv3      <= {pv3[1:0], r3_mem_en && !r3_mem_we};
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
        if (r3_mem_en) begin
            pipe3[0] <= mem3[r3_mem_addr];
            if (r3_mem_we)
                for (int b = 0; b < 4; b++)
                    if (r3_mem_be[b]) mem3[r3_mem_addr][8*b +: 8] <= r3_mem_wdata[8*b +: 8];
        end
    end
    assign r3_mem_rdata = pv3[2] ? pipe3[2] : 32'hBAD0BAD0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Drive one request (caller sits at a negedge), follow it to its response.
    task automatic run_req(input string name, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err, input int lat,
                           input logic [9:0] exp_maddr, input logic [3:0] exp_be,
                           input logic [31:0] exp_mwdata, input bit hold);
        int   wt, mem_k, mem_n, k;
        bit   got;
        rsp_t r;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        wt = 0;
        while (!s_ready && wt < 20) begin
            @(negedge clk);
            wt++;
        end
        chk({name, " accept"}, {31'd0, s_ready}, 32'd1);
        sb_q.push_back('{rdata: exp_rdata, err: exp_err});
        @(posedge clk);
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
        mem_k = 0;
        mem_n = 0;
        got   = 0;
        for (k = 1; k <= 12 && !got; k++) begin
            if (s_mem_en) begin
                mem_n++;
                if (mem_k == 0) begin
                    mem_k = k;
                    chk({name, " mem_we"},   {31'd0, s_mem_we}, {31'd0, we});
                    chk({name, " mem_addr"}, {22'd0, s_mem_addr}, {22'd0, exp_maddr});
                    chk({name, " mem_be"},   {28'd0, s_mem_be}, {28'd0, exp_be});
                    if (we) chk({name, " mem_wdata"}, s_mem_wdata, exp_mwdata);
                end
            end
            if (s_rsp_valid) begin
                got = 1;
                chk({name, " latency"}, k, lat);
                chk({name, " sb_nonempty"}, {31'd0, sb_q.size() > 0}, 32'd1);
                if (sb_q.size() > 0) begin
                    r = sb_q.pop_front();
                    chk({name, " rsp_rdata"}, s_rsp_rdata, r.rdata);
                    chk({name, " rsp_err"}, {31'd0, s_rsp_err}, {31'd0, r.err});
                end
            end else begin
                @(negedge clk);
            end
        end
        chk({name, " rsp_seen"}, {31'd0, got}, 32'd1);
        chk({name, " mem_en_cycle"}, mem_k, exp_err ? 0 : 1);
        chk({name, " mem_en_count"}, mem_n, exp_err ? 0 : 1);
        @(negedge clk);
        chk({name, " rsp_pulse"}, {31'd0, s_rsp_valid}, 32'd0);
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, " ready"},     {31'd0, s_ready}, 32'd1);
        chk({name, " rsp_valid"}, {31'd0, s_rsp_valid}, 32'd0);
        chk({name, " rsp_err"},   {31'd0, s_rsp_err}, 32'd0);
        chk({name, " rsp_rdata"}, s_rsp_rdata, 32'd0);
        chk({name, " mem_en"},    {31'd0, s_mem_en}, 32'd0);
        chk({name, " mem_we"},    {31'd0, s_mem_we}, 32'd0);
        chk({name, " mem_addr"},  {22'd0, s_mem_addr}, 32'd0);
        chk({name, " mem_be"},    {28'd0, s_mem_be}, 32'd0);
        chk({name, " mem_wdata"}, s_mem_wdata, 32'd0);
    endtask

    initial begin
        int seen;
        reset = 1'b1; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset1");
        sel = 1'b1;
        #1 chk_idle_outputs("reset3");
        sel = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        // Stores and byte/half lane steering (latency 1 instance).
        run_req("sw10",  1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0, 2, 10'd4, 4'b1111, 32'hDEADBEEF, 0);
        run_req("sb13",  1, 3'b000, 32'h13, 32'h000000A5, 0, 0, 2, 10'd4, 4'b1000, 32'hA5A5A5A5, 0);
        run_req("sh12",  1, 3'b001, 32'h12, 32'h00001234, 0, 0, 2, 10'd4, 4'b1100, 32'h12341234, 0);
        run_req("lw10",  0, 3'b010, 32'h10, 32'h0, 32'h1234BEEF, 0, 3, 10'd4, 4'b1111, 32'h0, 0);
        run_req("lwrap", 0, 3'b010, 32'h1010, 32'h0, 32'h1234BEEF, 0, 3, 10'd4, 4'b1111, 32'h0, 0);

        // Load extension on a known word.
        run_req("sw20",  1, 3'b010, 32'h20, 32'h80FF7F01, 0, 0, 2, 10'd8, 4'b1111, 32'h80FF7F01, 0);
        run_req("lb23",  0, 3'b000, 32'h23, 32'h0, 32'hFFFFFF80, 0, 3, 10'd8, 4'b1111, 32'h0, 0);
        run_req("lbu23", 0, 3'b100, 32'h23, 32'h0, 32'h00000080, 0, 3, 10'd8, 4'b1111, 32'h0, 0);
        run_req("lh20",  0, 3'b001, 32'h20, 32'h0, 32'h00007F01, 0, 3, 10'd8, 4'b1111, 32'h0, 0);
        run_req("lhu22", 0, 3'b101, 32'h22, 32'h0, 32'h000080FF, 0, 3, 10'd8, 4'b1111, 32'h0, 0);
        run_req("lb21",  0, 3'b000, 32'h21, 32'h0, 32'h0000007F, 0, 3, 10'd8, 4'b1111, 32'h0, 0);
        run_req("lh22",  0, 3'b001, 32'h22, 32'h0, 32'hFFFF80FF, 0, 3, 10'd8, 4'b1111, 32'h0, 0);

        // Misaligned and illegal requests never touch memory.
        run_req("elh11", 0, 3'b001, 32'h11, 32'h0, 32'h0, 1, 1, 10'd0, 4'b0, 32'h0, 0);
        run_req("elw22", 0, 3'b010, 32'h22, 32'h0, 32'h0, 1, 1, 10'd0, 4'b0, 32'h0, 0);
        run_req("eld3",  0, 3'b011, 32'h0,  32'h0, 32'h0, 1, 1, 10'd0, 4'b0, 32'h0, 0);
        run_req("eld6",  0, 3'b110, 32'h0,  32'h0, 32'h0, 1, 1, 10'd0, 4'b0, 32'h0, 0);
        run_req("est3",  1, 3'b011, 32'h0,  32'h1, 32'h0, 1, 1, 10'd0, 4'b0, 32'h0, 0);
        run_req("est4",  1, 3'b100, 32'h0,  32'h1, 32'h0, 1, 1, 10'd0, 4'b0, 32'h0, 0);
        run_req("esh13", 1, 3'b001, 32'h13, 32'h1, 32'h0, 1, 1, 10'd0, 4'b0, 32'h0, 0);
        run_req("esw21", 1, 3'b010, 32'h21, 32'h1, 32'h0, 1, 1, 10'd0, 4'b0, 32'h0, 0);
        run_req("lw20",  0, 3'b010, 32'h20, 32'h0, 32'h80FF7F01, 0, 3, 10'd8, 4'b1111, 32'h0, 0);

        // Latency-3 instance, back-to-back with req_valid held high.
        sel = 1'b1;
        run_req("sw40",  1, 3'b010, 32'h40, 32'hCAFEF00D, 0, 0, 2, 10'd16, 4'b1111, 32'hCAFEF00D, 0);
        run_req("lw40a", 0, 3'b010, 32'h40, 32'h0, 32'hCAFEF00D, 0, 5, 10'd16, 4'b1111, 32'h0, 1);
        chk("hold second_accept_ready", {31'd0, s_ready}, 32'd1);
        run_req("lw40b", 0, 3'b010, 32'h40, 32'h0, 32'hCAFEF00D, 0, 5, 10'd16, 4'b1111, 32'h0, 0);

        // Reset while the load is waiting on memory.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40;
        chk("abort accept", {31'd0, s_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("abort in_wait", {31'd0, s_ready}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_idle_outputs("abort");
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (s_rsp_valid) seen++;
        end
        chk("abort no_rsp", seen, 0);
        chk("sb drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
